wb_stage: RTL and testbench

- Write-back stage for the RV64 pipeline. It produces the register-file write port (wdata, wrd, wopcode) that the decode stage consumes on the falling clock edge.
- It merges two result sources: the ALU result channel and the load-data channel. Loads get byte/half/word extraction with sign or zero extension.
- Results drain through an in-order queue, so writes to the same rd retire in program order, at most one write per cycle.

---
 rtl/wb_stage.sv | 155 +++++++++++++++
 tb/tb_wb_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the RV64 pipeline.
//   Merges the ALU result channel and the load-data channel into one in-order
//   queue and presents at most one register-file write per cycle.
//   Ports:
//     clk, rst            - core clock, asynchronous active-low reset
//     in_ready            - at least two queue slots free
//     alu_valid/opcode/rd/result              - ALU result channel
//     mem_valid/rd/func3/byte_off/rdata       - load-data channel
//     wdata, wrd, wopcode - registered register-file write port
//                           (wrd=0, wopcode=branch means no write)
//     pending             - entries queued behind the output register
module wb_stage #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       in_ready,
  input  logic                       alu_valid,
  input  logic [6:0]                 alu_opcode,
  input  logic [4:0]                 alu_rd,
  input  logic [XLEN-1:0]            alu_result,
  input  logic                       mem_valid,
  input  logic [4:0]                 mem_rd,
  input  logic [2:0]                 mem_func3,
  input  logic [2:0]                 mem_byte_off,
  input  logic [XLEN-1:0]            mem_rdata,
  output logic [XLEN-1:0]            wdata,
  output logic [4:0]                 wrd,
  output logic [6:0]                 wopcode,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic [6:0]      op;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  entry_t          out_q, out_d;

  logic [2:0]      ld_off;
  logic [XLEN-1:0] ld_lane;
  logic [XLEN-1:0] ld_data;
  logic            mem_acc, alu_acc;
  entry_t          mem_ent, alu_ent;
  logic            new0_v, new1_v;
  entry_t          new0, new1;
  logic            pop;
  logic            push_a_v, push_b_v;
  entry_t          push_a, push_b;
  logic [AW-1:0]   tail_p1;

  assign in_ready = (count_q <= CW'(DEPTH - 2));

  // Load lane select: misaligned offsets are rounded down to natural alignment.
  always_comb begin
    ld_off = mem_byte_off;
    case (mem_func3[1:0])
      2'b01:   ld_off[0]   = 1'b0;
      2'b10:   ld_off[1:0] = 2'b00;
      2'b11:   ld_off      = 3'b000;
      default: ld_off      = mem_byte_off;
    endcase
    ld_lane = mem_rdata >> {ld_off, 3'b000};
    case (mem_func3)
      3'b000:  ld_data = {{(XLEN-8){ld_lane[7]}},   ld_lane[7:0]};
      3'b001:  ld_data = {{(XLEN-16){ld_lane[15]}}, ld_lane[15:0]};
      3'b010:  ld_data = {{(XLEN-32){ld_lane[31]}}, ld_lane[31:0]};
      3'b011:  ld_data = ld_lane;
      3'b100:  ld_data = {{(XLEN-8){1'b0}},  ld_lane[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_lane[15:0]};
      3'b110:  ld_data = {{(XLEN-32){1'b0}}, ld_lane[31:0]};
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    mem_acc = in_ready && mem_valid && (mem_rd != 5'd0);
    alu_acc = in_ready && alu_valid && (alu_rd != 5'd0)
              && (alu_opcode != OP_STORE) && (alu_opcode != OP_BRANCH);
    mem_ent = '{data: ld_data,    rd: mem_rd, op: OP_LOAD};
    alu_ent = '{data: alu_result, rd: alu_rd, op: alu_opcode};
    // Load is the older instruction when both arrive together.
    new0_v  = mem_acc || alu_acc;
    new0    = mem_acc ? mem_ent : alu_ent;
    new1_v  = mem_acc && alu_acc;
    new1    = alu_ent;
  end

  // Queue head has priority; an empty queue lets the oldest new entry bypass
  // straight into the output register.
  always_comb begin
    mem_d    = mem_q;
    out_d    = '{data: '0, rd: '0, op: OP_BRANCH};
    pop      = 1'b0;
    push_a_v = 1'b0;
    push_b_v = 1'b0;
    push_a   = new0;
    push_b   = new1;
    tail_p1  = tail_q + AW'(1);

    if (count_q != '0) begin
      out_d    = mem_q[head_q];
      pop      = 1'b1;
      push_a_v = new0_v;
      push_b_v = new1_v;
    end else if (new0_v) begin
      out_d    = new0;
      push_a   = new1;
      push_a_v = new1_v;
    end

    if (push_a_v) mem_d[tail_q]  = push_a;
    if (push_b_v) mem_d[tail_p1] = push_b;

    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + AW'(push_a_v) + AW'(push_b_v);
    count_d = count_q + CW'(push_a_v) + CW'(push_b_v) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      out_q   <= '{data: '0, rd: '0, op: OP_BRANCH};
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

  assign wdata   = out_q.data;
  assign wrd     = out_q.rd;
  assign wopcode = out_q.op;
  assign pending = count_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned PW    = $clog2(DEPTH) + 1;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  logic            clk;
  logic            rst;
  logic            in_ready;
  logic            alu_valid;
  logic [6:0]      alu_opcode;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_result;
  logic            mem_valid;
  logic [4:0]      mem_rd;
  logic [2:0]      mem_func3;
  logic [2:0]      mem_byte_off;
  logic [XLEN-1:0] mem_rdata;
  logic [XLEN-1:0] wdata;
  logic [4:0]      wrd;
  logic [6:0]      wopcode;
  logic [PW-1:0]   pending;

  wb_stage #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_ready(in_ready),
    .alu_valid(alu_valid), .alu_opcode(alu_opcode), .alu_rd(alu_rd),
    .alu_result(alu_result),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_func3(mem_func3),
    .mem_byte_off(mem_byte_off), .mem_rdata(mem_rdata),
    .wdata(wdata), .wrd(wrd), .wopcode(wopcode), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic [63:0] d;
    logic [4:0]  rd;
    logic [6:0]  op;
  } item_t;

  typedef struct {
    logic [2:0]  f3;
    logic [2:0]  off;
    logic [63:0] rdata;
    logic [63:0] exp;
  } ld_vec_t;

  item_t       mq[$];
  item_t       exp_out;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] rf [32];
  logic        last_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Load result from the architectural rules: size in bytes, offset rounded
  // down to a multiple of the size, then mask and optionally sign-fill.
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] off,
                                           input logic [63:0] rdata);
    int unsigned sz;
    int unsigned al;
    logic [63:0] v;
    logic [63:0] mask;
    sz = 1 << f3[1:0];
    al = (int'(off) / sz) * sz;
    if (f3 == 3'b111) return 64'd0;
    v = rdata >> (8 * al);
    if (sz < 8) begin
      mask = (64'd1 << (8 * sz)) - 64'd1;
      v = v & mask;
      if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic set_idle();
    alu_valid    = 1'b0;
    alu_opcode   = OP_REG;
    alu_rd       = 5'd0;
    alu_result   = '0;
    mem_valid    = 1'b0;
    mem_rd       = 5'd0;
    mem_func3    = 3'b000;
    mem_byte_off = 3'b000;
    mem_rdata    = '0;
  endtask

  // One clock: model acceptance from the inputs currently applied, then the
  // single in-order retirement, then compare after the edge.
  task automatic step();
    bit ready_m;
    ready_m = (mq.size() <= int'(DEPTH) - 2);
    chk("in_ready", 64'(in_ready), 64'(ready_m));
    last_ready = ready_m;
    if (ready_m) begin
      if (mem_valid && mem_rd != 5'd0)
        mq.push_back('{d: ref_load(mem_func3, mem_byte_off, mem_rdata), rd: mem_rd, op: OP_LOAD});
      if (alu_valid && alu_rd != 5'd0 && alu_opcode != OP_STORE && alu_opcode != OP_BRANCH)
        mq.push_back('{d: alu_result, rd: alu_rd, op: alu_opcode});
    end
    if (mq.size() > 0) exp_out = mq.pop_front();
    else               exp_out = '{d: 64'd0, rd: 5'd0, op: OP_BRANCH};
    @(posedge clk);
    #1;
    chk("wrd", 64'(wrd), 64'(exp_out.rd));
    chk("wopcode", 64'(wopcode), 64'(exp_out.op));
    if (exp_out.rd != 5'd0) chk("wdata", wdata, exp_out.d);
    chk("pending", 64'(pending), 64'(mq.size()));
    if (wrd != 5'd0) rf[wrd] = wdata;
  endtask

  task automatic rand_inputs();
    logic [6:0] ops [4];
    ops[0] = OP_STORE; ops[1] = OP_BRANCH; ops[2] = OP_REG; ops[3] = OP_IMM;
    mem_valid    = ($urandom % 3) != 0;
    mem_rd       = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
    mem_func3    = 3'($urandom);
    mem_byte_off = 3'($urandom);
    mem_rdata    = {$urandom, $urandom};
    alu_valid    = ($urandom % 3) != 0;
    alu_opcode   = ops[$urandom % 4];
    alu_rd       = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
    alu_result   = {$urandom, $urandom};
  endtask

  ld_vec_t ldv [11];
  int      max_pend;
  bit      saw_block;

  initial begin
    ldv[0]  = '{3'b000, 3'd3, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
    ldv[1]  = '{3'b010, 3'd4, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0000};
    ldv[2]  = '{3'b000, 3'd3, 64'h0000_0000_F000_0000, 64'hFFFF_FFFF_FFFF_FFF0};
    ldv[3]  = '{3'b100, 3'd3, 64'h0000_0000_F000_0000, 64'h0000_0000_0000_00F0};
    ldv[4]  = '{3'b001, 3'd3, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001};
    ldv[5]  = '{3'b101, 3'd3, 64'h0000_0000_8001_0000, 64'h0000_0000_0000_8001};
    ldv[6]  = '{3'b010, 3'd1, 64'h1234_5678_8765_4321, 64'hFFFF_FFFF_8765_4321};
    ldv[7]  = '{3'b110, 3'd6, 64'h1234_5678_8765_4321, 64'h0000_0000_1234_5678};
    ldv[8]  = '{3'b011, 3'd5, 64'h1234_5678_8765_4321, 64'h1234_5678_8765_4321};
    ldv[9]  = '{3'b111, 3'd0, 64'h1234_5678_8765_4321, 64'h0000_0000_0000_0000};
    ldv[10] = '{3'b000, 3'd7, 64'h7F00_0000_0000_0000, 64'h0000_0000_0000_007F};

    for (int i = 0; i < 32; i++) rf[i] = 64'd0;
    set_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wdata", wdata, 64'd0);
    chk("rst_wrd", 64'(wrd), 64'd0);
    chk("rst_wopcode", 64'(wopcode), 64'(OP_BRANCH));
    chk("rst_pending", 64'(pending), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;

    // ALU bypass into an empty queue, then idle.
    alu_valid = 1'b1; alu_opcode = OP_REG; alu_rd = 5'd5; alu_result = 64'h1234;
    step();
    chk("bypass_wdata", wdata, 64'h1234);
    chk("bypass_wrd", 64'(wrd), 64'd5);
    chk("bypass_op", 64'(wopcode), 64'(OP_REG));
    set_idle();
    step();
    chk("bypass_idle_wrd", 64'(wrd), 64'd0);
    chk("bypass_idle_op", 64'(wopcode), 64'(OP_BRANCH));

    // Load extraction table.
    for (int i = 0; i < 11; i++) begin
      mem_valid = 1'b1; mem_rd = 5'd1;
      mem_func3 = ldv[i].f3; mem_byte_off = ldv[i].off; mem_rdata = ldv[i].rdata;
      step();
      chk($sformatf("load_vec%0d", i), wdata, ldv[i].exp);
      chk($sformatf("load_op%0d", i), 64'(wopcode), 64'(OP_LOAD));
    end
    set_idle();
    step();

    // Same-edge load and ALU to rd 7: load retires first.
    mem_valid = 1'b1; mem_rd = 5'd7; mem_func3 = 3'b011; mem_byte_off = 3'd0;
    mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    alu_valid = 1'b1; alu_opcode = OP_REG; alu_rd = 5'd7; alu_result = 64'h5555_6666_7777_8888;
    step();
    chk("simul_first_op", 64'(wopcode), 64'(OP_LOAD));
    chk("simul_first_data", wdata, 64'hAAAA_BBBB_CCCC_DDDD);
    set_idle();
    step();
    chk("simul_second_op", 64'(wopcode), 64'(OP_REG));
    chk("simul_rf7", rf[7], 64'h5555_6666_7777_8888);
    step();

    // Dropped entries consume nothing.
    alu_valid = 1'b1; alu_opcode = OP_STORE;  alu_rd = 5'd3; alu_result = 64'd9;
    step();
    chk("drop_store_wrd", 64'(wrd), 64'd0);
    alu_opcode = OP_BRANCH;
    step();
    chk("drop_branch_wrd", 64'(wrd), 64'd0);
    alu_opcode = OP_REG; alu_rd = 5'd0;
    step();
    chk("drop_rd0_wrd", 64'(wrd), 64'd0);
    chk("drop_pending", 64'(pending), 64'd0);
    set_idle();
    mem_valid = 1'b1; mem_rd = 5'd0; mem_rdata = 64'hFF;
    step();
    chk("drop_ld_rd0_wrd", 64'(wrd), 64'd0);
    set_idle();

    // Backpressure: both sources held valid, fresh values only once accepted.
    max_pend  = 0;
    saw_block = 1'b0;
    mem_func3 = 3'b011;
    alu_opcode = OP_IMM;
    for (int c = 0; c < 20; c++) begin
      if (c == 0 || last_ready) begin
        mem_valid = 1'b1; mem_rd = 5'(c % 31 + 1); mem_rdata = 64'h1000 + 64'(c);
        alu_valid = 1'b1; alu_rd = 5'((c + 3) % 31 + 1); alu_result = 64'h2000 + 64'(c);
      end
      step();
      if (int'(pending) > max_pend) max_pend = int'(pending);
      if (!in_ready) saw_block = 1'b1;
    end
    chk("bp_max_pending", 64'(max_pend), 64'(DEPTH - 1));
    chk("bp_saw_block", 64'(saw_block), 64'd1);
    set_idle();
    for (int c = 0; c < 8 && mq.size() > 0; c++) step();
    step();
    chk("bp_drained", 64'(pending), 64'd0);

    // Randomized traffic; inputs held while not accepted.
    rand_inputs();
    for (int c = 0; c < 400; c++) begin
      step();
      if (last_ready) rand_inputs();
    end
    set_idle();
    for (int c = 0; c < 8 && mq.size() > 0; c++) step();

    // Asynchronous reset with three entries queued.
    mem_valid = 1'b1; mem_rd = 5'd9;  mem_func3 = 3'b011; mem_rdata = 64'hABC;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_opcode = OP_REG; alu_result = 64'hDEF;
    repeat (3) step();
    chk("pre_rst_pending", 64'(pending), 64'd3);
    set_idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_rst_wrd", 64'(wrd), 64'd0);
    chk("async_rst_op", 64'(wopcode), 64'(OP_BRANCH));
    chk("async_rst_pending", 64'(pending), 64'd0);
    chk("async_rst_wdata", wdata, 64'd0);
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
